// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared floating-point format constants, helpers and field struct
//
// Default exponent/mantissa widths, the exponent bias function, the all-ones
// exponent constant and a packed {sign, exp, mantissa} view of a float.
// Shared by the FPU datapath blocks (imported with fpu_pkg::*).
package fpu_pkg;

   localparam int FPU_EW = 8;
   localparam int FPU_MW = 23;

   // All-ones exponent for the default format (infinity / NaN encodings).
   localparam logic [FPU_EW-1:0] FPU_EXP_ONES = '1;

   typedef struct packed {
      logic              sign;
      logic [FPU_EW-1:0] exp;
      logic [FPU_MW-1:0] man;
   } fpu_float_t;

   // Exponent bias for an ew-bit exponent field: 2^(ew-1) - 1.
   function automatic int fpu_bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // All-ones exponent value for an ew-bit exponent field.
   function automatic int fpu_exp_ones(input int ew);
      return (1 << ew) - 1;
   endfunction

endpackage

// File: rtl/fmul_mant_mul.sv
// rtl/fmul_mant_mul.sv - significand multiplier built from half-width partial products
//
// Ports:
//   clk, rstn  clock and asynchronous active-low reset (used only when REG_PP=1)
//   en         partial-product register enable (pipeline advance)
//   a, b       N-bit significands including the implicit one
//   p          2N-bit product
// REG_PP=1 registers the four partial products, so p lags a/b by one enabled
// edge; REG_PP=0 is purely combinational.
module fmul_mant_mul #(
   parameter int N      = 24,
   parameter bit REG_PP = 1'b1
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           en,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   localparam int L  = N / 2;
   localparam int H  = N - L;
   localparam int PW = 2 * N;

   logic [2*L-1:0]   pp_ll, q_ll;
   logic [L+H-1:0]   pp_lh, pp_hl, q_lh, q_hl;
   logic [2*H-1:0]   pp_hh, q_hh;

   assign pp_ll = a[L-1:0] * b[L-1:0];
   assign pp_lh = a[L-1:0] * b[N-1:L];
   assign pp_hl = a[N-1:L] * b[L-1:0];
   assign pp_hh = a[N-1:L] * b[N-1:L];

   generate
      if (REG_PP) begin : g_reg
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               q_ll <= '0;
               q_lh <= '0;
               q_hl <= '0;
               q_hh <= '0;
            end else if (en) begin
               q_ll <= pp_ll;
               q_lh <= pp_lh;
               q_hl <= pp_hl;
               q_hh <= pp_hh;
            end
         end
      end else begin : g_comb
         logic unused_ctl;
         assign unused_ctl = clk ^ rstn ^ en;
         assign q_ll = pp_ll;
         assign q_lh = pp_lh;
         assign q_hl = pp_hl;
         assign q_hh = pp_hh;
      end
   endgenerate

   // Recombine: hh carries weight 2^(2L), the cross terms 2^L.
   assign p = {q_hh, {(2*L){1'b0}}}
            + (PW'(q_lh) << L)
            + (PW'(q_hl) << L)
            + PW'(q_ll);

endmodule

// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - pipelined floating-point multiplier with valid/ready handshake
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake for x1, x2 ({sign, exp, mantissa})
//   out_valid/out_ready  result handshake for y and ovf (overflow to infinity)
// Parameters: EW exponent width, MW mantissa width, STAGES latency (1..4).
// Build option: FMUL_ROUND_EN selects round-to-nearest-even; otherwise the
// discarded mantissa bits are truncated. Latency is the same either way.
// Exponent-0 operands flush to zero; denormal results flush to zero.
module fmul_pipe
   import fpu_pkg::*;
#(
   parameter int EW     = FPU_EW,
   parameter int MW     = FPU_MW,
   parameter int STAGES = 2
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [EW+MW:0] x1,
   input  logic [EW+MW:0] x2,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [EW+MW:0] y,
   output logic           ovf
);

   localparam int N  = MW + 1;
   localparam int PW = 2 * N;
   localparam int XW = EW + 2;
   localparam logic [XW-1:0]        BIAS   = XW'(fpu_bias(EW));
   localparam logic [EW-1:0]        ONES   = EW'(fpu_exp_ones(EW));
   localparam logic signed [XW-1:0] ONES_X = $signed({2'b00, ONES});

   // ---------------- handshake / valid pipeline ----------------
   logic              advance;
   logic [STAGES-1:0] vld;

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld[STAGES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld <= '0;
      end else if (advance) begin
         vld[0] <= in_valid;
         for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
      end
   end

   // ---------------- stage A: classify, exponent sum, partial products ----------------
   logic [EW-1:0] e1, e2;
   logic          a_sign, a_zero, a_spec;
   logic [XW-1:0] a_esum;

   assign e1     = x1[EW+MW-1:MW];
   assign e2     = x2[EW+MW-1:MW];
   assign a_sign = x1[EW+MW] ^ x2[EW+MW];
   assign a_zero = (e1 == '0) || (e2 == '0);
   assign a_spec = (e1 == ONES) || (e2 == ONES);
   // Two's-complement at EW+2 bits: covers 2 - bias .. 2*(2^EW-1) - bias.
   assign a_esum = {2'b00, e1} + {2'b00, e2} - BIAS;

   logic [PW-1:0] prod;

   fmul_mant_mul #(
      .N      (N),
      .REG_PP (STAGES >= 2)
   ) u_mant_mul (
      .clk  (clk),
      .rstn (rstn),
      .en   (advance),
      .a    ({1'b1, x1[MW-1:0]}),
      .b    ({1'b1, x2[MW-1:0]}),
      .p    (prod)
   );

   // Side-band follows the partial products through the same register point.
   logic          b_sign, b_zero, b_spec;
   logic [XW-1:0] b_esum;

   generate
      if (STAGES >= 2) begin : g_r1
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               b_sign <= 1'b0;
               b_zero <= 1'b0;
               b_spec <= 1'b0;
               b_esum <= '0;
            end else if (advance) begin
               b_sign <= a_sign;
               b_zero <= a_zero;
               b_spec <= a_spec;
               b_esum <= a_esum;
            end
         end
      end else begin : g_c1
         assign b_sign = a_sign;
         assign b_zero = a_zero;
         assign b_spec = a_spec;
         assign b_esum = a_esum;
      end
   endgenerate

   // ---------------- stage B: normalise ----------------
   // Product lies in [1,4); the leading one is prod[PW-1] or prod[PW-2].
   // shifted drops that leading one, leaving mantissa, guard and sticky bits.
   logic          norm;
   logic [PW-2:0] shifted;
   logic [MW-1:0] b_mant;
   logic          b_guard, b_sticky;
   logic [XW-1:0] b_exp;

   assign norm     = prod[PW-1];
   assign shifted  = norm ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
   assign b_mant   = shifted[PW-2 -: MW];
   assign b_guard  = shifted[PW-2-MW];
   assign b_sticky = |shifted[PW-3-MW:0];
   assign b_exp    = b_esum + XW'(norm);

   logic          c_sign, c_zero, c_spec, c_guard, c_sticky;
   logic [XW-1:0] c_exp;
   logic [MW-1:0] c_mant;

   generate
      if (STAGES >= 3) begin : g_r2
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               c_sign   <= 1'b0;
               c_zero   <= 1'b0;
               c_spec   <= 1'b0;
               c_exp    <= '0;
               c_mant   <= '0;
               c_guard  <= 1'b0;
               c_sticky <= 1'b0;
            end else if (advance) begin
               c_sign   <= b_sign;
               c_zero   <= b_zero;
               c_spec   <= b_spec;
               c_exp    <= b_exp;
               c_mant   <= b_mant;
               c_guard  <= b_guard;
               c_sticky <= b_sticky;
            end
         end
      end else begin : g_c2
         assign c_sign   = b_sign;
         assign c_zero   = b_zero;
         assign c_spec   = b_spec;
         assign c_exp    = b_exp;
         assign c_mant   = b_mant;
         assign c_guard  = b_guard;
         assign c_sticky = b_sticky;
      end
   endgenerate

   // ---------------- stage C: round and pack ----------------
   logic          rnd;
   logic [MW:0]   mant_r;
   logic [XW-1:0] exp_r;

`ifdef FMUL_ROUND_EN
   assign rnd = c_guard & (c_sticky | c_mant[0]);
`else
   logic unused_rnd;
   assign unused_rnd = c_guard ^ c_sticky;
   assign rnd        = 1'b0;
`endif

   // A rounding carry out of the mantissa leaves mant_r[MW-1:0] all zero,
   // which is exactly the mantissa of the next binade.
   assign mant_r = {1'b0, c_mant} + (MW+1)'(rnd);
   assign exp_r  = c_exp + XW'(mant_r[MW]);

   logic [EW+MW:0] p_y;
   logic           p_ovf;

   always_comb begin
      p_ovf = 1'b0;
      if (c_zero) begin
         p_y = {c_sign, {(EW+MW){1'b0}}};
      end else if (c_spec) begin
         p_y = {c_sign, ONES, {MW{1'b0}}};
      end else if ($signed(c_exp) <= 0) begin
         p_y = {c_sign, {(EW+MW){1'b0}}};
      end else if ($signed(exp_r) >= ONES_X) begin
         p_y   = {c_sign, ONES, {MW{1'b0}}};
         p_ovf = 1'b1;
      end else begin
         p_y = {c_sign, exp_r[EW-1:0], mant_r[MW-1:0]};
      end
   end

   logic [EW+MW:0] d_y;
   logic           d_ovf;

   generate
      if (STAGES >= 4) begin : g_r3
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               d_y   <= '0;
               d_ovf <= 1'b0;
            end else if (advance) begin
               d_y   <= p_y;
               d_ovf <= p_ovf;
            end
         end
      end else begin : g_c3
         assign d_y   = p_y;
         assign d_ovf = p_ovf;
      end
   endgenerate

   // ---------------- output register ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         y   <= '0;
         ovf <= 1'b0;
      end else if (advance) begin
         y   <= d_y;
         ovf <= d_ovf;
      end
   end

endmodule
